gpu_ddr_avalon_bridge: RTL

Pipelined bridge sitting directly downstream of the GPU memory adapter's Avalon-MM master port (17-bit 64-bit-word address, 3-bit burst) and upstream of the board DDR controller slave. It does four things:
- Decouples timing with a 2-entry skid buffer.
- Relocates the 1 MB VRAM window to a programmable DDR base.
- Widens the burst count.
- Bounds outstanding read beats so that returning data never overruns downstream consumers.

---
 rtl/gpu_ddr_pkg.sv | 32 +++
 rtl/gpu_ddr_skid2.sv | 75 +++++++
 rtl/gpu_ddr_avalon_bridge.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/gpu_ddr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_ddr_pkg
// Description : Shared types and helpers for the GPU-to-DDR Avalon bridge.
//               Holds the upstream address/burst widths, the non-address
//               part of a skid-buffer entry and the burst normaliser.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_ddr_pkg;

    localparam int GPU_BURST_W = 3;
    localparam int GPU_ADR_W   = 17;

    // Skid entry minus the address. The DDR address width is a parameter
    // of the top level, so the top concatenates {addr, skid_meta_t}.
    typedef struct packed {
        logic                   we;
        logic [GPU_BURST_W-1:0] burst;
        logic [63:0]            data;
        logic [7:0]             be;
        logic                   first;
    } skid_meta_t;

    // A zero-length burst is treated as a single beat.
    function automatic logic [GPU_BURST_W-1:0] burst_norm(
        input logic [GPU_BURST_W-1:0] b
    );
        return (b == '0) ? GPU_BURST_W'(1) : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_ddr_skid2.sv
`default_nettype none
// ============================================================================
// Module      : gpu_ddr_skid2
// Description : Generic 2-entry skid buffer. Entry 0 is always the head.
//               o_busy is registered: it is high exactly when the buffer
//               will hold two entries after the current edge.
// Ports       : clk, i_rst         - clock, synchronous active-high reset
//               i_push, i_data     - enqueue request and payload
//               o_busy             - registered full indication
//               i_pop              - dequeue head (ignored when empty)
//               o_valid, o_data    - head valid and head payload
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_ddr_skid2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_busy,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_ent0;
    logic [WIDTH-1:0] r_ent1;
    logic             r_busy;

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_cnt_nxt;

    assign w_push    = i_push & ~r_busy;
    assign w_pop     = i_pop & (r_cnt != 2'd0);
    assign w_cnt_nxt = r_cnt + 2'(w_push) - 2'(w_pop);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_cnt  <= 2'd0;
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_busy <= (w_cnt_nxt == 2'd2);
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_ent0 <= i_data;
                    else               r_ent1 <= i_data;
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_ent0 <= i_data;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy  = r_busy;
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_ent0;

endmodule
`default_nettype wire

// File: rtl/gpu_ddr_avalon_bridge.sv
`default_nettype none
// ============================================================================
// Module      : gpu_ddr_avalon_bridge
// Description : Pipelined Avalon-MM bridge from the GPU memory adapter to the
//               DDR controller. Buffers requests in a 2-entry skid buffer,
//               relocates the VRAM window to i_baseAddr, widens the burst
//               count and limits outstanding read beats to MAX_RD_BEATS.
// Ports       : clk, i_rst                 - clock, sync active-high reset
//               i_baseAddr                 - DDR word address of VRAM word 0
//               i_targetAddr/i_burstLength - upstream address / beats
//               i_writeEnableMem/i_readEnableMem/i_dataMem/i_byteEnableMem
//                                          - upstream command and data
//               o_busyMem                  - upstream waitrequest
//               o_dataValidMem/o_dataMem   - read return toward upstream
//               o_ddr_*, i_ddr_*           - DDR controller master port
//               o_err                      - sticky protocol error flag
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_ddr_avalon_bridge
    import gpu_ddr_pkg::*;
#(
    parameter int DDR_AW       = 29,
    parameter int MAX_RD_BEATS = 16,
    parameter int BC_W         = 8
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic [DDR_AW-1:0]      i_baseAddr,
    input  logic [GPU_ADR_W-1:0]   i_targetAddr,
    input  logic [GPU_BURST_W-1:0] i_burstLength,
    output logic                   o_busyMem,
    input  logic                   i_writeEnableMem,
    input  logic                   i_readEnableMem,
    input  logic [63:0]            i_dataMem,
    input  logic [7:0]             i_byteEnableMem,
    output logic                   o_dataValidMem,
    output logic [63:0]            o_dataMem,
    output logic [DDR_AW-1:0]      o_ddr_address,
    output logic [BC_W-1:0]        o_ddr_burstcount,
    input  logic                   i_ddr_waitrequest,
    output logic                   o_ddr_write,
    output logic                   o_ddr_read,
    output logic [63:0]            o_ddr_writedata,
    output logic [7:0]             o_ddr_byteenable,
    input  logic                   i_ddr_readdatavalid,
    input  logic [63:0]            i_ddr_readdata,
    output logic                   o_err
);

    localparam int CNT_W  = $clog2(MAX_RD_BEATS) + 1;
    localparam int CRD_W  = CNT_W + 1;
    localparam int META_W = $bits(skid_meta_t);
    localparam int ENT_W  = DDR_AW + META_W;

    // ------------------------------------------------------------------
    // Upstream accept and write-burst tracking
    // ------------------------------------------------------------------
    logic [GPU_BURST_W-1:0] r_wcnt;
    logic [DDR_AW-1:0]      r_wr_addr;
    logic [GPU_BURST_W-1:0] r_wr_burst;

    logic                   w_skid_busy;
    logic                   w_acc;
    logic                   w_first;
    logic                   w_drop;
    logic                   w_push;
    logic                   w_use_new;
    logic [GPU_BURST_W-1:0] w_bnorm;
    logic [DDR_AW-1:0]      w_xlat;
    skid_meta_t             w_in_meta;
    logic [ENT_W-1:0]       w_in_ent;

    // Busy is forced high while in reset; the registered part clears to 0
    // so the first cycle after reset already accepts.
    assign o_busyMem = w_skid_busy | i_rst;

    assign w_acc     = (i_writeEnableMem | i_readEnableMem) & ~o_busyMem;
    assign w_first   = (r_wcnt == '0);
    // A pure read in the middle of a write burst is discarded.
    assign w_drop    = ~i_writeEnableMem & ~w_first;
    assign w_push    = w_acc & ~w_drop;
    assign w_bnorm   = burst_norm(i_burstLength);
    assign w_xlat    = i_baseAddr + DDR_AW'(i_targetAddr);
    // Continuation beats of a write burst reuse the first beat's address
    // and burst so the DDR side sees a constant command for the burst.
    assign w_use_new = ~i_writeEnableMem | w_first;

    always_comb begin
        w_in_meta       = '0;
        w_in_meta.we    = i_writeEnableMem;
        w_in_meta.burst = w_use_new ? w_bnorm : r_wr_burst;
        w_in_meta.data  = i_dataMem;
        w_in_meta.be    = i_byteEnableMem;
        w_in_meta.first = w_first;
    end

    assign w_in_ent = {(w_use_new ? w_xlat : r_wr_addr), w_in_meta};

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wcnt     <= '0;
            r_wr_addr  <= '0;
            r_wr_burst <= '0;
        end else if (w_acc & i_writeEnableMem) begin
            if (w_first) begin
                r_wcnt     <= w_bnorm - GPU_BURST_W'(1);
                r_wr_addr  <= w_xlat;
                r_wr_burst <= w_bnorm;
            end else begin
                r_wcnt     <= r_wcnt - GPU_BURST_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    logic             w_head_valid;
    logic [ENT_W-1:0] w_head_ent;
    logic             w_pop;

    gpu_ddr_skid2 #(
        .WIDTH (ENT_W)
    ) u_skid (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_in_ent),
        .o_busy  (w_skid_busy),
        .i_pop   (w_pop),
        .o_valid (w_head_valid),
        .o_data  (w_head_ent)
    );

    // ------------------------------------------------------------------
    // DDR issue with read credit
    // ------------------------------------------------------------------
    skid_meta_t        w_head_meta;
    logic [DDR_AW-1:0] w_head_addr;
    logic [CNT_W-1:0]  r_outst;
    logic [CRD_W-1:0]  w_crd_sum;
    logic              w_credit_ok;
    logic              w_rd_pop;
    logic [CNT_W-1:0]  w_add;
    logic [CNT_W-1:0]  w_sub;
    logic              w_unused;

    assign w_head_meta = skid_meta_t'(w_head_ent[META_W-1:0]);
    assign w_head_addr = w_head_ent[ENT_W-1 -: DDR_AW];
    assign w_unused    = w_head_meta.first;

    // Extra bit keeps the sum from wrapping when outstanding is near max.
    assign w_crd_sum   = {1'b0, r_outst} + CRD_W'(w_head_meta.burst);
    assign w_credit_ok = (w_crd_sum <= CRD_W'(MAX_RD_BEATS));

    assign o_ddr_write      = w_head_valid & w_head_meta.we;
    assign o_ddr_read       = w_head_valid & ~w_head_meta.we & w_credit_ok;
    assign o_ddr_address    = w_head_addr;
    assign o_ddr_burstcount = BC_W'(w_head_meta.burst);
    assign o_ddr_writedata  = w_head_meta.data;
    assign o_ddr_byteenable = w_head_meta.be;

    assign w_pop    = (o_ddr_write | o_ddr_read) & ~i_ddr_waitrequest;
    assign w_rd_pop = o_ddr_read & ~i_ddr_waitrequest;
    assign w_add    = w_rd_pop ? CNT_W'(w_head_meta.burst) : '0;
    assign w_sub    = (i_ddr_readdatavalid & (r_outst != '0)) ? CNT_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_outst <= '0;
        end else begin
            r_outst <= r_outst + w_add - w_sub;
        end
    end

    // ------------------------------------------------------------------
    // Read return and sticky error
    // ------------------------------------------------------------------
    logic        r_rdv;
    logic [63:0] r_rdata;
    logic        r_err;
    logic        w_err_set;

    assign w_err_set = (w_acc & i_writeEnableMem & i_readEnableMem)
                     | (w_acc & w_use_new & (i_burstLength == '0))
                     | (w_acc & w_drop)
                     | (i_ddr_readdatavalid & (r_outst == '0));

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_rdv   <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_rdv   <= i_ddr_readdatavalid;
            r_rdata <= i_ddr_readdata;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign o_dataValidMem = r_rdv;
    assign o_dataMem      = r_rdata;
    assign o_err          = r_err;

endmodule
`default_nettype wire
